nv_fifo_ctrl_64x18: RTL and testbench



---
 rtl/nv_fifo_ctrl_64x18.sv | 115 +++++++++++
 tb/tb_nv_fifo_ctrl_64x18.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/nv_fifo_ctrl_64x18.sv
// rtl/nv_fifo_ctrl_64x18.sv - valid/ready FIFO controller around a 64x18 two-port register-file RAM

module nv_fifo_ctrl_64x18 #(
  parameter int DEPTH = 64,
  parameter int AW    = 6,
  parameter int DW    = 18
) (
  input  logic          clk,
  input  logic          rst,
  // upstream
  input  logic          wr_pvld,
  output logic          wr_prdy,
  input  logic [DW-1:0] wr_pd,
  // downstream
  output logic          rd_pvld,
  input  logic          rd_prdy,
  output logic [DW-1:0] rd_pd,
  // RAM ports
  output logic          ram_we,
  output logic [AW-1:0] ram_wa,
  output logic [DW-1:0] ram_di,
  output logic          ram_re,
  output logic [AW-1:0] ram_ra,
  input  logic [DW-1:0] ram_dout,
  // power-down bus
  input  logic [31:0]   pwrbus_ram_pd,
  output logic [31:0]   pwrbus_ram_pd_o,
  // occupancy
  output logic [AW+1:0] fifo_cnt
);

  localparam logic [AW:0] RAM_FULL = (AW+1)'(DEPTH);

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   ram_cnt_q, ram_cnt_d;
  logic          rd_inflight_q, rd_inflight_d;
  logic [1:0]    out_cnt_q, out_cnt_d;
  logic [DW-1:0] head_q, head_d;
  logic [DW-1:0] skid_q, skid_d;

  logic          push;
  logic          pop;
  logic [2:0]    rd_slots_used;
  logic [1:0]    out_cnt_after_pop;

  // Handshakes and RAM port drive; the write side is purely combinational.
  always_comb begin
    wr_prdy       = (ram_cnt_q != RAM_FULL) & ~rst;
    push          = wr_pvld & wr_prdy;
    rd_pvld       = (out_cnt_q != 2'd0);
    pop           = rd_pvld & rd_prdy;
    rd_pd         = head_q;

    ram_we        = push;
    ram_wa        = wr_ptr_q;
    ram_di        = wr_pd;

    // Slots already spoken for once this cycle's pop leaves: issue only if one stays free.
    rd_slots_used = 3'(out_cnt_q) + 3'(rd_inflight_q) - 3'(pop);
    ram_re        = ~rst & (ram_cnt_q != '0) & (rd_slots_used < 3'd2);
    ram_ra        = rd_ptr_q;

    pwrbus_ram_pd_o = pwrbus_ram_pd;
    fifo_cnt      = (AW+2)'(ram_cnt_q) + (AW+2)'(out_cnt_q) + (AW+2)'(rd_inflight_q);
  end

  // Pointer and RAM occupancy next state; the slot is freed when the read is issued.
  always_comb begin
    wr_ptr_d      = push   ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d      = ram_re ? rd_ptr_q + 1'b1 : rd_ptr_q;
    ram_cnt_d     = ram_cnt_q + (AW+1)'(push) - (AW+1)'(ram_re);
    rd_inflight_d = ram_re;
  end

  // Output buffer: shift skid into head on pop, then land returning RAM data in the first free slot.
  always_comb begin
    head_d            = head_q;
    skid_d            = skid_q;
    out_cnt_after_pop = out_cnt_q - 2'(pop);
    if (pop) begin
      head_d = skid_q;
    end
    if (rd_inflight_q) begin
      if (out_cnt_after_pop == 2'd0) begin
        head_d = ram_dout;
      end else begin
        skid_d = ram_dout;
      end
    end
    out_cnt_d = out_cnt_after_pop + 2'(rd_inflight_q);
  end

  // State registers; reset discards everything held, including a read in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      ram_cnt_q     <= '0;
      rd_inflight_q <= 1'b0;
      out_cnt_q     <= 2'd0;
      head_q        <= '0;
      skid_q        <= '0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      ram_cnt_q     <= ram_cnt_d;
      rd_inflight_q <= rd_inflight_d;
      out_cnt_q     <= out_cnt_d;
      head_q        <= head_d;
      skid_q        <= skid_d;
    end
  end

endmodule

// File: tb/tb_nv_fifo_ctrl_64x18.sv
// tb/tb_nv_fifo_ctrl_64x18.sv - scoreboard bench for nv_fifo_ctrl_64x18 with a behavioural 64x18 RAM

module tb_nv_fifo_ctrl_64x18;

  logic        clk;
  logic        rst;
  logic        wr_pvld;
  logic        wr_prdy;
  logic [17:0] wr_pd;
  logic        rd_pvld;
  logic        rd_prdy;
  logic [17:0] rd_pd;
  logic        ram_we;
  logic [5:0]  ram_wa;
  logic [17:0] ram_di;
  logic        ram_re;
  logic [5:0]  ram_ra;
  logic [17:0] ram_dout;
  logic [31:0] pwrbus_ram_pd;
  logic [31:0] pwrbus_ram_pd_o;
  logic [7:0]  fifo_cnt;

  int checks = 0;
  int errors = 0;
  logic [17:0] sb_q[$];

  nv_fifo_ctrl_64x18 dut (
    .clk             (clk),
    .rst             (rst),
    .wr_pvld         (wr_pvld),
    .wr_prdy         (wr_prdy),
    .wr_pd           (wr_pd),
    .rd_pvld         (rd_pvld),
    .rd_prdy         (rd_prdy),
    .rd_pd           (rd_pd),
    .ram_we          (ram_we),
    .ram_wa          (ram_wa),
    .ram_di          (ram_di),
    .ram_re          (ram_re),
    .ram_ra          (ram_ra),
    .ram_dout        (ram_dout),
    .pwrbus_ram_pd   (pwrbus_ram_pd),
    .pwrbus_ram_pd_o (pwrbus_ram_pd_o),
    .fifo_cnt        (fifo_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model: write port plus registered read address; contents survive reset
  logic [17:0] mem [64];
  logic [5:0]  ra_reg;
  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 18'h0;
    ra_reg = 6'd0;
  end
  always @(posedge clk) begin
    if (ram_we) mem[ram_wa] <= ram_di;
    if (ram_re) ra_reg <= ram_ra;
  end
  assign ram_dout = mem[ra_reg];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic r_st, input logic v, input logic [17:0] d, input logic r);
    @(negedge clk);
    rst = r_st; wr_pvld = v; wr_pd = d; rd_prdy = r;
    #2;
  endtask

  // Monitor / scoreboard
  logic was_rst = 1'b0;
  initial begin
    logic [17:0] exp_pd;
    forever begin
      @(negedge clk);
      #1;
      if (rst) begin
        chk("wr_prdy_in_rst", {31'd0, wr_prdy}, 32'd0);
        chk("ram_we_in_rst", {31'd0, ram_we}, 32'd0);
        chk("ram_re_in_rst", {31'd0, ram_re}, 32'd0);
        sb_q.delete();
        was_rst = 1'b1;
      end else begin
        if (was_rst) chk("rd_pvld_after_rst", {31'd0, rd_pvld}, 32'd0);
        chk("fifo_cnt_vs_model", {24'd0, fifo_cnt}, 32'(sb_q.size()));
        chk("pwrbus_passthru", pwrbus_ram_pd_o, pwrbus_ram_pd);
        if (rd_pvld && rd_prdy) begin
          checks++;
          if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL pop_from_empty actual=%0h expected=no_pop", rd_pd);
          end else begin
            exp_pd = sb_q.pop_front();
            if (rd_pd !== exp_pd) begin
              errors++;
              $display("FAIL sb_rd_pd actual=%0h expected=%0h", rd_pd, exp_pd);
            end
          end
        end
        if (wr_pvld && wr_prdy) sb_q.push_back(wr_pd);
        was_rst = 1'b0;
      end
    end
  end

  // Stimulus
  initial begin
    int n;
    int pops;
    int stalls;
    int bubbles;
    int wa_wraps;
    int ra_wraps;
    rst = 1'b1; wr_pvld = 1'b0; wr_pd = 18'h0; rd_prdy = 1'b0;
    pwrbus_ram_pd = 32'h5A5A_00C3;
    drive(1, 0, 18'h0, 0);
    drive(1, 0, 18'h0, 0);

    // reset state
    drive(0, 0, 18'h0, 0);
    chk("rst_rd_pvld", {31'd0, rd_pvld}, 32'd0);
    chk("rst_fifo_cnt", {24'd0, fifo_cnt}, 32'd0);
    chk("rst_rd_pd", {14'd0, rd_pd}, 32'd0);
    chk("rst_ram_re", {31'd0, ram_re}, 32'd0);
    chk("idle_wr_prdy", {31'd0, wr_prdy}, 32'd1);

    // three words, fill latency of two edges after the accepting edge
    drive(0, 1, 18'h00001, 1); chk("t1_c0_pvld", {31'd0, rd_pvld}, 32'd0);
    drive(0, 1, 18'h00002, 1); chk("t1_c1_pvld", {31'd0, rd_pvld}, 32'd0);
    drive(0, 1, 18'h00003, 1); chk("t1_c2_pvld", {31'd0, rd_pvld}, 32'd0);
    drive(0, 0, 18'h0, 1);
    chk("t1_c3_pvld", {31'd0, rd_pvld}, 32'd1);
    chk("t1_c3_pd", {14'd0, rd_pd}, 32'h1);
    drive(0, 0, 18'h0, 1);
    chk("t1_c4_pvld", {31'd0, rd_pvld}, 32'd1);
    chk("t1_c4_pd", {14'd0, rd_pd}, 32'h2);
    drive(0, 0, 18'h0, 1);
    chk("t1_c5_pvld", {31'd0, rd_pvld}, 32'd1);
    chk("t1_c5_pd", {14'd0, rd_pd}, 32'h3);
    drive(0, 0, 18'h0, 1);
    chk("t1_empty_pvld", {31'd0, rd_pvld}, 32'd0);
    chk("t1_empty_cnt", {24'd0, fifo_cnt}, 32'd0);

    // fill to 66 with downstream stalled, then drain back to back
    n = 0;
    for (int i = 0; i < 70; i++) begin
      drive(0, 1, 18'(n), 0);
      if (wr_prdy) n++;
    end
    chk("full_accepts", 32'(n), 32'd66);
    drive(0, 0, 18'h0, 0);
    chk("full_fifo_cnt", {24'd0, fifo_cnt}, 32'd66);
    chk("full_wr_prdy", {31'd0, wr_prdy}, 32'd0);
    chk("full_ram_re", {31'd0, ram_re}, 32'd0);
    pops = 0;
    for (int i = 0; i < 66; i++) begin
      drive(0, 0, 18'h0, 1);
      if (rd_pvld) pops++;
      chk("drain_pd", {14'd0, rd_pd}, 32'(i));
    end
    chk("drain_pops", 32'(pops), 32'd66);
    drive(0, 0, 18'h0, 1);
    chk("drain_empty_pvld", {31'd0, rd_pvld}, 32'd0);

    // streaming from clean pointers: no stalls, no bubbles, three wraps on each port
    drive(1, 0, 18'h0, 0);
    stalls = 0; bubbles = 0; wa_wraps = 0; ra_wraps = 0;
    for (int i = 0; i < 200; i++) begin
      drive(0, 1, 18'(32'h1000 + i), 1);
      if (!wr_prdy) stalls++;
      if (i >= 3 && !rd_pvld) bubbles++;
      if (ram_we && ram_wa == 6'd63) wa_wraps++;
      if (ram_re && ram_ra == 6'd63) ra_wraps++;
    end
    for (int i = 0; i < 6; i++) begin
      drive(0, 0, 18'h0, 1);
      if (ram_re && ram_ra == 6'd63) ra_wraps++;
    end
    chk("stream_stalls", 32'(stalls), 32'd0);
    chk("stream_bubbles", 32'(bubbles), 32'd0);
    chk("stream_wa_wraps", 32'(wa_wraps), 32'd3);
    chk("stream_ra_wraps", 32'(ra_wraps), 32'd3);
    chk("stream_end_pvld", {31'd0, rd_pvld}, 32'd0);

    // random valid/ready
    for (int i = 0; i < 2000; i++) begin
      drive(0, 1'($urandom_range(0, 1)), 18'($urandom), 1'($urandom_range(0, 1)));
    end
    for (int i = 0; i < 80; i++) drive(0, 0, 18'h0, 1);
    chk("rand_drained", {24'd0, fifo_cnt}, 32'd0);

    // reset with 40 held and a read in flight
    n = 0;
    for (int i = 0; i < 100 && n < 41; i++) begin
      drive(0, 1, 18'(32'h100 + n), 0);
      if (wr_prdy) n++;
    end
    chk("mid_accepts", 32'(n), 32'd41);
    drive(0, 0, 18'h0, 1);
    chk("mid_pop_issues_read", {31'd0, ram_re}, 32'd1);
    drive(1, 0, 18'h0, 0);
    chk("mid_held_before_rst", {24'd0, fifo_cnt}, 32'd40);
    drive(0, 1, 18'h2AAAA, 1);
    chk("post_rst_pvld", {31'd0, rd_pvld}, 32'd0);
    chk("post_rst_cnt", {24'd0, fifo_cnt}, 32'd0);
    chk("post_rst_wr_prdy", {31'd0, wr_prdy}, 32'd1);
    drive(0, 0, 18'h0, 1); chk("post_rst_c1_pvld", {31'd0, rd_pvld}, 32'd0);
    drive(0, 0, 18'h0, 1); chk("post_rst_c2_pvld", {31'd0, rd_pvld}, 32'd0);
    drive(0, 0, 18'h0, 1);
    chk("post_rst_c3_pvld", {31'd0, rd_pvld}, 32'd1);
    chk("post_rst_c3_pd", {14'd0, rd_pd}, 32'h2AAAA);
    drive(0, 0, 18'h0, 1); chk("post_rst_c4_pvld", {31'd0, rd_pvld}, 32'd0);

    // simultaneous push and pop with one entry sitting in the head slot
    drive(0, 1, 18'h15555, 0);
    drive(0, 0, 18'h0, 0);
    drive(0, 0, 18'h0, 0);
    drive(0, 1, 18'h0ABCD, 1);
    chk("pp_head_pvld", {31'd0, rd_pvld}, 32'd1);
    chk("pp_head_pd", {14'd0, rd_pd}, 32'h15555);
    chk("pp_wr_prdy", {31'd0, wr_prdy}, 32'd1);
    drive(0, 0, 18'h0, 1);
    chk("pp_c1_pvld", {31'd0, rd_pvld}, 32'd0);
    chk("pp_c1_cnt", {24'd0, fifo_cnt}, 32'd1);
    chk("pp_c1_re", {31'd0, ram_re}, 32'd1);
    drive(0, 0, 18'h0, 1);
    chk("pp_c2_pvld", {31'd0, rd_pvld}, 32'd0);
    drive(0, 0, 18'h0, 1);
    chk("pp_c3_pvld", {31'd0, rd_pvld}, 32'd1);
    chk("pp_c3_pd", {14'd0, rd_pd}, 32'h0ABCD);
    drive(0, 0, 18'h0, 1);
    chk("pp_end_pvld", {31'd0, rd_pvld}, 32'd0);
    chk("pp_end_cnt", {24'd0, fifo_cnt}, 32'd0);

    drive(0, 0, 18'h0, 0);
    chk("sb_empty_at_end", 32'(sb_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
